lfsr_stim_gen: RTL and testbench

//  Hardware pseudo-random stimulus source sitting directly upstream of the d_ff under test.
//  - Produces NUM_TESTS random data samples on d from a 16-bit Galois LFSR.
//  - Inserts a pseudo-random idle gap of 0..MAX_DELAY-1 cycles between samples.
//  - Makes random DFF testing repeatable (seeded) and synthesizable, replacing $random stimulus.

---
 rtl/lfsr_stim_gen.sv | 157 +++++++++++++++
 tb/tb_lfsr_stim_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stim_gen.sv
// ---------------------------------------------------------------------------
// lfsr_stim_gen
// Repeatable, synthesizable pseudo-random stimulus source for a downstream
// flip-flop under test. A 16-bit Galois LFSR supplies both the data samples
// and the idle gap inserted before each sample.
//
// Optional feature macro: STIM_FIXED_DELAY_EN
//   defined   -> every gap is MAX_DELAY-1 idle cycles (sample period MAX_DELAY+1)
//   undefined -> gap is lfsr[15:8] % MAX_DELAY (sample period gap+2)
//   The LFSR steps identically in both builds, so the data sequence matches.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   start      begin a run (accepted only in IDLE or DONE)
//   seed_load  load seed_in into the LFSR (accepted only in IDLE or DONE)
//   seed_in    new seed; zero is replaced by SEED
//   d          sample data; holds the last sample between pulses
//   d_valid    one-cycle strobe per new sample
//   busy       run in progress (DELAY or DRIVE)
//   done       run completed; held until next start or reset
//   count      samples issued in the current/last run
// ---------------------------------------------------------------------------
module lfsr_stim_gen #(
    parameter int          WIDTH     = 1,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          NUM_TESTS = 10,
    parameter int          MAX_DELAY = 10,
    localparam int         CNT_W     = $clog2(NUM_TESTS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             seed_load,
    input  logic [15:0]      seed_in,
    output logic [WIDTH-1:0] d,
    output logic             d_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    localparam int DLY_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // One Galois step with feedback taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Gap length chosen from the current LFSR value at each delay load.
    function automatic logic [DLY_W-1:0] dly_pick(input logic [15:0] v);
`ifdef STIM_FIXED_DELAY_EN
        return DLY_W'(MAX_DELAY - 1);
`else
        return DLY_W'({24'h000000, v[15:8]} % 32'(MAX_DELAY));
`endif
    endfunction

    logic [1:0]       state_r,   state_nxt_s;
    logic [15:0]      lfsr_r,    lfsr_nxt_s;
    logic [DLY_W-1:0] dly_r,     dly_nxt_s;
    logic [WIDTH-1:0] d_r,       d_nxt_s;
    logic             d_valid_r, d_valid_nxt_s;
    logic             busy_r,    busy_nxt_s;
    logic             done_r,    done_nxt_s;
    logic [CNT_W-1:0] count_r,   count_nxt_s;
    logic [CNT_W-1:0] count_inc_s;

    assign count_inc_s = count_r + CNT_W'(1);

    // Next-state and next-output computation for the run sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        lfsr_nxt_s    = lfsr_r;
        dly_nxt_s     = dly_r;
        d_nxt_s       = d_r;
        d_valid_nxt_s = 1'b0;
        done_nxt_s    = done_r;
        count_nxt_s   = count_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                // seed_load wins over a simultaneous start
                if (seed_load) begin
                    lfsr_nxt_s = (seed_in == 16'h0000) ? SEED : seed_in;
                end else if (start) begin
                    count_nxt_s = {CNT_W{1'b0}};
                    done_nxt_s  = 1'b0;
                    dly_nxt_s   = dly_pick(lfsr_r);
                    lfsr_nxt_s  = lfsr_step(lfsr_r);
                    state_nxt_s = ST_DELAY;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DELAY: begin
                if (dly_r != {DLY_W{1'b0}}) begin
                    dly_nxt_s = dly_r - DLY_W'(1);
                end else begin
                    d_nxt_s       = lfsr_r[WIDTH-1:0];
                    d_valid_nxt_s = 1'b1;
                    lfsr_nxt_s    = lfsr_step(lfsr_r);
                    state_nxt_s   = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                count_nxt_s = count_inc_s;
                if (count_inc_s == CNT_W'(NUM_TESTS)) begin
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    dly_nxt_s   = dly_pick(lfsr_r);
                    lfsr_nxt_s  = lfsr_step(lfsr_r);
                    state_nxt_s = ST_DELAY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_DELAY) || (state_nxt_s == ST_DRIVE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            lfsr_r    <= SEED;
            dly_r     <= {DLY_W{1'b0}};
            d_r       <= {WIDTH{1'b0}};
            d_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            count_r   <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            lfsr_r    <= lfsr_nxt_s;
            dly_r     <= dly_nxt_s;
            d_r       <= d_nxt_s;
            d_valid_r <= d_valid_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            count_r   <= count_nxt_s;
        end
    end

    assign d       = d_r;
    assign d_valid = d_valid_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign count   = count_r;

endmodule

// File: tb/tb_lfsr_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_lfsr_stim_gen
// Directed bench for lfsr_stim_gen (WIDTH=8, default SEED, NUM_TESTS=10).
// Expected samples and gaps are hand-computed from the LFSR recurrence
// starting at 16'hACE1. With STIM_FIXED_DELAY_EN defined, MAX_DELAY=4 and
// every sample period is 5 cycles; the data sequence is the same.
// ---------------------------------------------------------------------------
module tb_lfsr_stim_gen;

    localparam int WIDTH     = 8;
    localparam int NUM_TESTS = 10;
`ifdef STIM_FIXED_DELAY_EN
    localparam int MAX_DELAY = 4;
    localparam bit FIXED     = 1'b1;
`else
    localparam int MAX_DELAY = 10;
    localparam bit FIXED     = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic             seed_load;
    logic [15:0]      seed_in;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             busy;
    logic             done;
    logic [3:0]       count;

    int tests_run    = 0;
    int tests_failed = 0;

    // First run from SEED: sample data and the gap chosen before each sample.
    logic [7:0] exp_d   [10] = '{8'h70, 8'h9C, 8'h27, 8'h89, 8'h62,
                                 8'h58, 8'h16, 8'hC5, 8'hB1, 8'h6C};
    int         exp_dly [10] = '{2, 3, 8, 9, 4, 8, 6, 1, 5, 2};

    lfsr_stim_gen #(
        .WIDTH    (WIDTH),
        .SEED     (16'hACE1),
        .NUM_TESTS(NUM_TESTS),
        .MAX_DELAY(MAX_DELAY)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .seed_load(seed_load),
        .seed_in  (seed_in),
        .d        (d),
        .d_valid  (d_valid),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the edge where the request is driven to the d_valid cycle.
    function automatic int gap(input int dly);
        return FIXED ? (MAX_DELAY + 1) : (dly + 2);
    endfunction

    // Wait (bounded) for the next d_valid and check its timing, data and count.
    task automatic wait_valid(input string tag, input logic [7:0] ed, input int ecyc,
                              input int cyc0, input int ecnt);
        int         cyc    = cyc0;
        logic [7:0] held   = d;
        bit         stable = 1'b1;
        bit         seen   = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            cyc++;
            if (d_valid) begin
                seen = 1'b1;
                break;
            end
            if (d !== held) stable = 1'b0;
        end
        check({tag, "_seen"},   32'(seen),   32'd1);
        check({tag, "_cycles"}, 32'(cyc),    32'(ecyc));
        check({tag, "_d"},      32'(d),      32'(ed));
        check({tag, "_count"},  32'(count),  32'(ecnt));
        check({tag, "_busy"},   32'(busy),   32'd1);
        check({tag, "_stable"}, 32'(stable), 32'd1);
    endtask

    task automatic check_idle(input string tag, input logic [7:0] ed, input int ecnt,
                              input bit edone);
        check({tag, "_d"},       32'(d),       32'(ed));
        check({tag, "_d_valid"}, 32'(d_valid), 32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_done"},    32'(done),    32'(edone));
        check({tag, "_count"},   32'(count),   32'(ecnt));
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b1;
        seed_load = 1'b0;
        seed_in   = 16'h0000;

        // T1: reset for two cycles with start held high
        tick();
        tick();
        check_idle("t1_reset", 8'h00, 0, 1'b0);
        start = 1'b0;
        reset = 1'b1;
        tick();
        check_idle("t1_post", 8'h00, 0, 1'b0);

        // T2/T3: full run from SEED
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("t2_s0", exp_d[0], gap(exp_dly[0]), 1, 0);
        for (int k = 1; k < NUM_TESTS; k++) begin
            wait_valid($sformatf("t3_s%0d", k), exp_d[k], gap(exp_dly[k]), 0, k);
        end
        tick();
        check_idle("t3_done", 8'h6C, NUM_TESTS, 1'b1);
        tick();
        tick();
        check_idle("t3_hold", 8'h6C, NUM_TESTS, 1'b1);

        // Restart from DONE continues the LFSR (no reseed)
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_done_cleared", 32'(done), 32'd0);
        wait_valid("rs_s0", 8'hDB, gap(5), 1, 0);

        // seed_load and start while busy are ignored
        seed_load = 1'b1;
        seed_in   = 16'h1234;
        start     = 1'b1;
        tick();
        seed_load = 1'b0;
        start     = 1'b0;
        wait_valid("t4_busy_seed", 8'h76, gap(8), 1, 1);

        // Reset mid-run aborts without done
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_idle("abort1", 8'h00, 0, 1'b0);

        // T4: seed_load beats start; zero seed maps to SEED
        seed_load = 1'b1;
        seed_in   = 16'h1234;
        start     = 1'b1;
        tick();
        check_idle("t4_seed_vs_start", 8'h00, 0, 1'b0);
        start   = 1'b0;
        seed_in = 16'h0000;
        tick();
        seed_load = 1'b0;
        check_idle("t4_seed_zero", 8'h00, 0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("t4_s0", exp_d[0], gap(exp_dly[0]), 1, 0);
        wait_valid("t4_s1", exp_d[1], gap(exp_dly[1]), 0, 1);
        wait_valid("t4_s2", exp_d[2], gap(exp_dly[2]), 0, 2);

        // T5: reset after the third sample, then restart
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_idle("t5_abort", 8'h00, 0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid("t5_s0", exp_d[0], gap(exp_dly[0]), 1, 0);
        check("t5_no_done", 32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
